// File: rtl/dma_bus_arbiter_pkg.sv
// Shared definitions for the CPU/DMA bus arbiter: FSM state codes, 8288 status
// codes and the registered output bundle decoded from each state.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    ST_CPU       = 3'b000,
    ST_WAIT_IDLE = 3'b001,
    ST_SWITCH    = 3'b010,
    ST_DMA       = 3'b011,
    ST_RELEASE   = 3'b100
  } state_t;

  // 8288 S2..S0 status codes; also used by the bus-controller bench.
  localparam logic [2:0] S_INTA    = 3'b000;
  localparam logic [2:0] S_IORD    = 3'b001;
  localparam logic [2:0] S_IOWR    = 3'b010;
  localparam logic [2:0] S_HALT    = 3'b011;
  localparam logic [2:0] S_CODE    = 3'b100;
  localparam logic [2:0] S_MEMRD   = 3'b101;
  localparam logic [2:0] S_MEMWR   = 3'b110;
  localparam logic [2:0] S_PASSIVE = 3'b111;

  typedef struct packed {
    logic       hlda;
    logic       aen_n;
    logic       dma_aen_n;
    logic       cpu_hold;
    logic [1:0] bus_owner;
  } arb_out_t;

  // RELEASE reports the guard code on bus_owner so 00 only shows once the CPU owns the bus.
  function automatic arb_out_t outs_of(state_t s);
    arb_out_t o;
    case (s)
      ST_CPU:       o = '{hlda: 1'b0, aen_n: 1'b0, dma_aen_n: 1'b1, cpu_hold: 1'b0, bus_owner: 2'b00};
      ST_WAIT_IDLE: o = '{hlda: 1'b0, aen_n: 1'b0, dma_aen_n: 1'b1, cpu_hold: 1'b1, bus_owner: 2'b01};
      ST_SWITCH:    o = '{hlda: 1'b0, aen_n: 1'b1, dma_aen_n: 1'b1, cpu_hold: 1'b1, bus_owner: 2'b10};
      ST_DMA:       o = '{hlda: 1'b1, aen_n: 1'b1, dma_aen_n: 1'b0, cpu_hold: 1'b1, bus_owner: 2'b11};
      ST_RELEASE:   o = '{hlda: 1'b0, aen_n: 1'b1, dma_aen_n: 1'b1, cpu_hold: 1'b1, bus_owner: 2'b10};
      default:      o = '{hlda: 1'b0, aen_n: 1'b0, dma_aen_n: 1'b1, cpu_hold: 1'b0, bus_owner: 2'b00};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_sync_chain.sv
// Asynchronous-reset flop chain bringing a single-bit asynchronous signal into clk.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its pre-edge neighbour and the chain shifts one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/dma_bus_arbiter.sv
// Hands the PC system bus between the 8088 and the 8237: waits for a passive,
// unlocked CPU bus, inserts guard cycles on every hand-over, stalls the CPU meanwhile.
module dma_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PASSIVE_CYCLES = 2,
  parameter int GUARD_CYCLES   = 2,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] s_n,
  input  logic       lock_n,
  input  logic       hrq,
  output logic       hlda,
  output logic       aen_n,
  output logic       dma_aen_n,
  output logic       cpu_hold,
  output logic [1:0] bus_owner
);

  localparam logic [CNT_W-1:0] PASS_LAST  = CNT_W'(PASSIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  logic             hrq_s;
  logic             passive;
  state_t           state;
  arb_out_t         outs;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] guard_cnt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_hrq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (hrq),
    .q     (hrq_s)
  );

  // A locked cycle counts as busy even when the status lines read passive.
  assign passive = (s_n == S_PASSIVE) && lock_n;

  // Outputs are decoded from the state being entered, so they change on the
  // same edge as the state and never see the inputs combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CPU;
      outs      <= outs_of(ST_CPU);
      pass_cnt  <= '0;
      guard_cnt <= '0;
    end else begin
      case (state)
        ST_CPU: begin
          if (hrq_s && lock_n) begin
            state    <= ST_WAIT_IDLE;
            outs     <= outs_of(ST_WAIT_IDLE);
            pass_cnt <= '0;
          end
        end

        ST_WAIT_IDLE: begin
          if (!hrq_s) begin
            state <= ST_CPU;
            outs  <= outs_of(ST_CPU);
          end else if (passive) begin
            if (pass_cnt == PASS_LAST) begin
              state     <= ST_SWITCH;
              outs      <= outs_of(ST_SWITCH);
              guard_cnt <= '0;
            end else begin
              pass_cnt <= pass_cnt + 1'b1;
            end
          end else begin
            pass_cnt <= '0;
          end
        end

        ST_SWITCH: begin
          if (!hrq_s) begin
            state     <= ST_RELEASE;
            outs      <= outs_of(ST_RELEASE);
            guard_cnt <= '0;
          end else if (guard_cnt == GUARD_LAST) begin
            state <= ST_DMA;
            outs  <= outs_of(ST_DMA);
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end

        ST_DMA: begin
          if (!hrq_s) begin
            state     <= ST_RELEASE;
            outs      <= outs_of(ST_RELEASE);
            guard_cnt <= '0;
          end
        end

        // A new request is ignored here; CPU re-arbitrates one edge after it regains the bus.
        ST_RELEASE: begin
          if (guard_cnt == GUARD_LAST) begin
            state <= ST_CPU;
            outs  <= outs_of(ST_CPU);
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_CPU;
          outs  <= outs_of(ST_CPU);
        end
      endcase
    end
  end

  assign hlda      = outs.hlda;
  assign aen_n     = outs.aen_n;
  assign dma_aen_n = outs.dma_aen_n;
  assign cpu_hold  = outs.cpu_hold;
  assign bus_owner = outs.bus_owner;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter: directed timelines push expected output
// snapshots per clock edge; a monitor compares them and checks bus invariants.
module tb_dma_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] s_n = 3'b111;
  logic       lock_n = 1'b1;
  logic       hrq = 1'b0;
  logic       hlda;
  logic       aen_n;
  logic       dma_aen_n;
  logic       cpu_hold;
  logic [1:0] bus_owner;

  dma_bus_arbiter #(
    .SYNC_STAGES    (2),
    .PASSIVE_CYCLES (2),
    .GUARD_CYCLES   (2),
    .CNT_W          (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_n       (s_n),
    .lock_n    (lock_n),
    .hrq       (hrq),
    .hlda      (hlda),
    .aen_n     (aen_n),
    .dma_aen_n (dma_aen_n),
    .cpu_hold  (cpu_hold),
    .bus_owner (bus_owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;     // edge after which to compare; -1 means compare immediately
    logic [5:0] v;     // {hlda, aen_n, dma_aen_n, cpu_hold, bus_owner}
    logic [5:0] m;
  } exp_t;

  exp_t  q[$];
  int    n_vec = 0;
  int    n_fail = 0;
  int    edge_cnt = 0;
  string cur_test = "none";
  event  ev_now;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Hand-derived output pattern per arbiter phase letter.
  function automatic exp_t exp_of(int e, byte c);
    exp_t x;
    x.e = e;
    x.m = 6'b111111;
    case (c)
      "C": x.v = 6'b001000;
      "W": x.v = 6'b001101;
      "S": x.v = 6'b011110;
      "D": x.v = 6'b110111;
      "R": begin x.v = 6'b011100; x.m = 6'b111100; end
      default: x.v = 6'b000000;
    endcase
    return x;
  endfunction

  task automatic push_seq(int first, string seq);
    for (int i = 0; i < seq.len(); i++) q.push_back(exp_of(first + i, seq[i]));
  endtask

  task automatic check(string name, logic [5:0] act, logic [5:0] exp, logic [5:0] mask);
    n_vec++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: got {hlda,aen_n,dma_aen_n,cpu_hold,owner}=%b, want %b (mask %b)",
               name, act, exp, mask);
    end
  endtask

  // Monitor: invariants every sample, then every expectation due at this point.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk or ev_now);
      if (rst_n) begin
        check($sformatf("%s excl e%0d", cur_test, edge_cnt),
              {5'b0, !(!aen_n && !dma_aen_n)}, 6'd1, 6'd1);
        check($sformatf("%s hlda_aen e%0d", cur_test, edge_cnt),
              {5'b0, (!hlda || aen_n)}, 6'd1, 6'd1);
      end
      while (q.size() > 0 && (q[0].e == -1 || q[0].e <= edge_cnt)) begin
        x = q.pop_front();
        if (x.e != -1 && x.e < edge_cnt) begin
          n_vec++;
          n_fail++;
          $display("FAIL %s missed e%0d: sampled at e%0d, required at e%0d",
                   cur_test, x.e, edge_cnt, x.e);
        end else begin
          check($sformatf("%s e%0d", cur_test, x.e),
                {hlda, aen_n, dma_aen_n, cpu_hold, bus_owner}, x.v, x.m);
        end
      end
    end
  end

  task automatic reset_to(string name, logic h, logic [2:0] s, logic l, string seq);
    @(negedge clk);
    rst_n    = 1'b0;
    hrq      = h;
    s_n      = s;
    lock_n   = l;
    cur_test = name;
    #1;
    push_seq(0, seq);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_before(int k);
    int guard = 0;
    while (edge_cnt != k - 1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s wait edge %0d: reached e%0d, required e%0d", cur_test, k, edge_cnt, k - 1);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s drain: %0d expectations left, required 0", cur_test, q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Grant, DMA ignores s_n/lock_n, release, re-request during RELEASE.
    reset_to("basic", 1'b1, 3'b111, 1'b1,
             {"CCCWWSS", "DDDDDDDDDDDDDDD", "RRCWWSSDD"});
    wait_before(10); s_n = 3'b101;
    wait_before(12); lock_n = 1'b0;
    wait_before(17); s_n = 3'b111; lock_n = 1'b1;
    wait_before(20); hrq = 1'b0;
    wait_before(22); hrq = 1'b1;
    drain();

    // Busy CPU: non-passive status through edge 8.
    reset_to("busy", 1'b1, 3'b100, 1'b1, "CCCWWWWWWWSSDD");
    wait_before(9); s_n = 3'b111;
    drain();

    // LOCK held through edge 10 blocks the hand-over entirely.
    reset_to("lock", 1'b1, 3'b111, 1'b0, "CCCCCCCCCCCWWSSDD");
    wait_before(11); lock_n = 1'b1;
    drain();

    // Short request pulse while the CPU stays busy.
    reset_to("early", 1'b1, 3'b101, 1'b1, "CCCWWWCCCC");
    wait_before(4); hrq = 1'b0;
    drain();

    // Request withdrawn during SWITCH goes through RELEASE.
    reset_to("sw_abort", 1'b1, 3'b111, 1'b1, "CCCWWSRRCCC");
    wait_before(4); hrq = 1'b0;
    drain();

    // Asynchronous reset while DMA owns the bus, then normal re-arbitration.
    reset_to("rst_mid", 1'b1, 3'b111, 1'b1, "CCCWWSSDD");
    wait_before(9);
    #1;
    rst_n = 1'b0;
    #1;
    q.push_back(exp_of(-1, "C"));
    -> ev_now;
    #2;
    rst_n = 1'b1;
    push_seq(1, "CCWWSSD");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
